// File: rtl/memory_access_scheduler_pkg.sv
// Shared constants for the memory access scheduler: source tags and FSM states.
package memory_sched_pkg;

  localparam logic MEMSCHED_SRC_INST = 1'b0;
  localparam logic MEMSCHED_SRC_DATA = 1'b1;

  typedef enum logic {
    MEMSCHED_ST_RUN   = 1'b0,
    MEMSCHED_ST_DRAIN = 1'b1
  } memsched_state_e;

endpackage

// File: rtl/memory_access_scheduler_if.sv
// Bundle of requester, memory-port and response signals around the scheduler.
interface memory_access_scheduler_if;

  logic        iDATA_REQ;
  logic        oDATA_LOCK;
  logic        iDATA_RW;
  logic [31:0] iDATA_ADDR;
  logic [31:0] iDATA_DATA;
  logic        iINST_REQ;
  logic        oINST_LOCK;
  logic [31:0] iINST_ADDR;
  logic        iDRAIN;
  logic        oIDLE;
  logic        oMEMORY_REQ;
  logic        iMEMORY_LOCK;
  logic        oMEMORY_RW;
  logic        oMEMORY_STORE_ACK;
  logic [31:0] oMEMORY_ADDR;
  logic [31:0] oMEMORY_DATA;
  logic        iMEMORY_VALID;
  logic        iMEMORY_STORE_ACK;
  logic [63:0] iMEMORY_DATA;
  logic        oDATA_VALID;
  logic [63:0] oDATA_DATA;
  logic        oINST_VALID;
  logic [63:0] oINST_DATA;
  logic        oPROTOCOL_ERR;

  modport slave (
    input  iDATA_REQ, iDATA_RW, iDATA_ADDR, iDATA_DATA,
    input  iINST_REQ, iINST_ADDR, iDRAIN,
    input  iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_STORE_ACK, iMEMORY_DATA,
    output oDATA_LOCK, oINST_LOCK, oIDLE,
    output oMEMORY_REQ, oMEMORY_RW, oMEMORY_STORE_ACK, oMEMORY_ADDR, oMEMORY_DATA,
    output oDATA_VALID, oDATA_DATA, oINST_VALID, oINST_DATA, oPROTOCOL_ERR
  );

  modport master (
    output iDATA_REQ, iDATA_RW, iDATA_ADDR, iDATA_DATA,
    output iINST_REQ, iINST_ADDR, iDRAIN,
    output iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_STORE_ACK, iMEMORY_DATA,
    input  oDATA_LOCK, oINST_LOCK, oIDLE,
    input  oMEMORY_REQ, oMEMORY_RW, oMEMORY_STORE_ACK, oMEMORY_ADDR, oMEMORY_DATA,
    input  oDATA_VALID, oDATA_DATA, oINST_VALID, oINST_DATA, oPROTOCOL_ERR
  );

endinterface

// File: rtl/memory_access_scheduler_tag_fifo.sv
// 1-bit source-tag FIFO recording which requester owns each outstanding read.
module memory_sched_tag_fifo #(
  parameter int TAG_DEPTH   = 16,
  parameter int TAG_DEPTH_N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic                 i_push_data,
  input  logic                 i_pop,
  output logic                 o_pop_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [TAG_DEPTH_N:0] o_count
);

  logic                   r_mem [TAG_DEPTH];
  logic [TAG_DEPTH_N-1:0] r_wr_ptr;
  logic [TAG_DEPTH_N-1:0] r_rd_ptr;
  logic [TAG_DEPTH_N:0]   r_count;
  logic                   w_push;
  logic                   w_pop;

  assign o_full     = (r_count == (TAG_DEPTH_N+1)'(TAG_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_access_scheduler.sv
// Single memory port arbiter: data priority with inst anti-starvation, read tag
// tracking, response routing and a drain mode for MMU switches.
module memory_access_scheduler
  import memory_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int TAG_DEPTH    = 16,
  parameter int TAG_DEPTH_N  = 4
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET,
  memory_access_scheduler_if.slave  bus
);

  memsched_state_e      r_state;
  logic [7:0]           r_starve_cnt;
  logic                 w_starved;
  logic                 w_data_win;
  logic                 w_inst_win;
  logic                 w_is_store;
  logic                 w_can_grant;
  logic                 w_data_grant;
  logic                 w_inst_grant;
  logic                 w_grant;
  logic                 w_push;
  logic                 w_pop_req;
  logic                 w_pop;
  logic                 w_tag;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [TAG_DEPTH_N:0] w_fifo_count;

  assign w_starved  = (r_starve_cnt == 8'(STARVE_LIMIT)) && bus.iINST_REQ;
  assign w_data_win = bus.iDATA_REQ && !w_starved;
  assign w_inst_win = bus.iINST_REQ && !w_data_win;
  assign w_is_store = w_data_win && bus.iDATA_RW;

  // Stores take no tag, so they can still go out while the tag FIFO is full.
  assign w_can_grant  = !bus.iMEMORY_LOCK && (r_state == MEMSCHED_ST_RUN) && !bus.iDRAIN
                        && (!w_fifo_full || w_is_store);
  assign w_data_grant = w_can_grant && w_data_win;
  assign w_inst_grant = w_can_grant && w_inst_win;
  assign w_grant      = w_data_grant || w_inst_grant;

  assign bus.oDATA_LOCK = !w_data_grant;
  assign bus.oINST_LOCK = !w_inst_grant;

  assign w_push    = w_grant && !w_is_store;
  assign w_pop_req = bus.iMEMORY_VALID && !bus.iMEMORY_STORE_ACK;
  assign w_pop     = w_pop_req && !w_fifo_empty;

  assign bus.oIDLE = (r_state == MEMSCHED_ST_DRAIN) && (w_fifo_count == '0) && !bus.oMEMORY_REQ;

  memory_sched_tag_fifo #(
    .TAG_DEPTH   (TAG_DEPTH),
    .TAG_DEPTH_N (TAG_DEPTH_N)
  ) u_tag_fifo (
    .i_clk       (iCLOCK),
    .i_rst       (iRESET),
    .i_push      (w_push),
    .i_push_data (w_data_win ? MEMSCHED_SRC_DATA : MEMSCHED_SRC_INST),
    .i_pop       (w_pop),
    .o_pop_data  (w_tag),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state      <= MEMSCHED_ST_RUN;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        MEMSCHED_ST_RUN:   if (bus.iDRAIN)  r_state <= MEMSCHED_ST_DRAIN;
        MEMSCHED_ST_DRAIN: if (!bus.iDRAIN) r_state <= MEMSCHED_ST_RUN;
        default:           r_state <= MEMSCHED_ST_RUN;
      endcase
      if (!bus.iINST_REQ || w_inst_grant)
        r_starve_cnt <= '0;
      else if (w_data_grant && (r_starve_cnt != 8'(STARVE_LIMIT)))
        r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      bus.oMEMORY_REQ       <= 1'b0;
      bus.oMEMORY_RW        <= 1'b0;
      bus.oMEMORY_STORE_ACK <= 1'b0;
      bus.oMEMORY_ADDR      <= '0;
      bus.oMEMORY_DATA      <= '0;
    end else if (w_grant) begin
      bus.oMEMORY_REQ       <= 1'b1;
      bus.oMEMORY_RW        <= w_data_grant && bus.iDATA_RW;
      bus.oMEMORY_STORE_ACK <= w_data_grant && bus.iDATA_RW;
      bus.oMEMORY_ADDR      <= w_data_grant ? bus.iDATA_ADDR : bus.iINST_ADDR;
      bus.oMEMORY_DATA      <= w_data_grant ? bus.iDATA_DATA : 32'd0;
    end else if (!bus.iMEMORY_LOCK) begin
      bus.oMEMORY_REQ       <= 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      bus.oDATA_VALID   <= 1'b0;
      bus.oDATA_DATA    <= '0;
      bus.oINST_VALID   <= 1'b0;
      bus.oINST_DATA    <= '0;
      bus.oPROTOCOL_ERR <= 1'b0;
    end else begin
      bus.oDATA_VALID <= (bus.iMEMORY_VALID && bus.iMEMORY_STORE_ACK)
                         || (w_pop && (w_tag == MEMSCHED_SRC_DATA));
      bus.oINST_VALID <= w_pop && (w_tag == MEMSCHED_SRC_INST);
      if (w_pop && (w_tag == MEMSCHED_SRC_DATA)) bus.oDATA_DATA <= bus.iMEMORY_DATA;
      if (w_pop && (w_tag == MEMSCHED_SRC_INST)) bus.oINST_DATA <= bus.iMEMORY_DATA;
      if (w_pop_req && w_fifo_empty) bus.oPROTOCOL_ERR <= 1'b1;
    end
  end

endmodule

// File: doc/memory_access_scheduler.md
# memory_access_scheduler

Arbitrates the single memory port between the core's data requester and instruction-fetch requester. It uses fixed data priority with an instruction anti-starvation counter, tracks outstanding reads in a source-tag FIFO, and routes each returning read or store-ack back to its originator. A drain mode lets the core quiesce the port before an MMU/PDT switch. Sits between the core load/store and fetch units and the MMU/memory port.

## Interface
- STARVE_LIMIT, 8: consecutive lost arbitration cycles after which inst wins the next grant (1..255).
- TAG_DEPTH, 16: outstanding-read tag FIFO depth (power of two).
- TAG_DEPTH_N, 4: log2(TAG_DEPTH).

Clocking: one clock; reset is asynchronous and active-high.

- iCLOCK  in  1  clock.
- iRESET  in  1  asynchronous active-high reset.
- iDATA_REQ  in  1  data request, held until accepted.
- oDATA_LOCK  out  1  combinational: data request not accepted this cycle.
- iDATA_RW  in  1  1 = store, 0 = load.
- iDATA_ADDR  in  32  data address.
- iDATA_DATA  in  32  store data.
- iINST_REQ  in  1  fetch request, held until accepted.
- oINST_LOCK  out  1  combinational: fetch not accepted this cycle.
- iINST_ADDR  in  32  fetch address.
- iDRAIN  in  1  level: stop granting new requests.
- oIDLE  out  1  drain complete: no outstanding reads, output register empty.
- oMEMORY_REQ  out  1  registered request to memory.
- iMEMORY_LOCK  in  1  memory cannot accept; output register holds.
- oMEMORY_RW  out  1  registered RW.
- oMEMORY_STORE_ACK  out  1  request is a store; no tag pushed.
- oMEMORY_ADDR  out  32  registered address.
- oMEMORY_DATA  out  32  registered store data (0 for fetch).
- iMEMORY_VALID  in  1  response valid.
- iMEMORY_STORE_ACK  in  1  response is a store acknowledge.
- iMEMORY_DATA  in  64  response data.
- oDATA_VALID  out  1  registered data response/store-ack.
- oDATA_DATA  out  64  registered data response.
- oINST_VALID  out  1  registered fetch response.
- oINST_DATA  out  64  registered fetch response.
- oPROTOCOL_ERR  out  1  sticky: read response with empty tag FIFO; cleared only by reset.

## Operation
- Grant is possible in a cycle only when all of these hold: !iMEMORY_LOCK, tag FIFO not full (evaluated before any same-cycle pop), state RUN. A store needs no tag, so it is exempt from the full check.
- Winner: inst if starve_cnt == STARVE_LIMIT and iINST_REQ; otherwise data if iDATA_REQ; otherwise inst if iINST_REQ.
- oDATA_LOCK = !(grant && winner == data). oINST_LOCK is the analogue for inst.
- starve_cnt (8 bit) increments when iINST_REQ, grant possible and data wins. It clears when inst is granted or !iINST_REQ. It saturates at STARVE_LIMIT.
- On grant, the output register loads the winner's fields and oMEMORY_REQ is set to 1. oMEMORY_STORE_ACK = data && iDATA_RW. A read pushes its tag (0 inst, 1 data).
- With no grant and !iMEMORY_LOCK, oMEMORY_REQ is cleared. With iMEMORY_LOCK, all output registers hold.
- Response routing:
  - iMEMORY_VALID && iMEMORY_STORE_ACK: pulse oDATA_VALID; no pop.
  - iMEMORY_VALID && !iMEMORY_STORE_ACK: pop the tag and route to inst or data.
  - A read response with an empty FIFO is dropped and sets oPROTOCOL_ERR.
- State machine (2 states):
  - RUN → DRAIN on iDRAIN.
  - DRAIN blocks grants. DRAIN → RUN when !iDRAIN.
  - oIDLE = (state == DRAIN) && FIFO empty && !oMEMORY_REQ.

## Timing
- Reset: every output register is 0. oMEMORY_* = 0, oDATA_VALID/oINST_VALID = 0, oPROTOCOL_ERR = 0, oIDLE = 0. starve_cnt = 0, FIFO empty, state RUN.
- A request accepted in cycle N appears on oMEMORY_* at N+1.
- A response in cycle M appears on oX_VALID/oX_DATA at M+1, a one-cycle pulse. Data outputs hold their last value.
- Simultaneous push and pop: both are performed and the count is unchanged. A pop on an empty FIFO is an error even if a push occurs in the same cycle.
- FIFO pointers wrap modulo TAG_DEPTH. The count is TAG_DEPTH_N+1 bits wide.
- iDRAIN asserted in cycle N: no grant in N. oIDLE can rise no earlier than N+1.
- Reset mid-operation discards all outstanding tags. Late responses after reset raise oPROTOCOL_ERR.

## Structure
- Package memory_sched_pkg holds:
  - the source-tag constants MEMSCHED_SRC_INST = 1'b0 and MEMSCHED_SRC_DATA = 1'b1;
  - the state encodings MEMSCHED_ST_RUN and MEMSCHED_ST_DRAIN.
- One sub-module, memory_sched_tag_fifo: a 1-bit-wide synchronous FIFO with full/empty/count, parameterised by TAG_DEPTH/TAG_DEPTH_N. Arbiter, counter, FSM and output registers stay in the top.

## Test plan
- Both requests held continuously, STARVE_LIMIT=8, no lock → 8 data grants, then 1 inst grant, repeating. oMEMORY_ADDR order matches.
- Inst fetch to 0x1000 accepted in cycle 5; response 0xDEAD_BEEF in cycle 9 → oINST_VALID=1 and oINST_DATA=0xDEADBEEF at cycle 10; oDATA_VALID stays 0.
- iMEMORY_LOCK high 3 cycles with data pending → oDATA_LOCK=1 and oMEMORY_* unchanged throughout; grant is issued the cycle lock drops.
- Issue 16 data loads with no responses → 17th load locked; a store in the same state is granted with oMEMORY_STORE_ACK=1; a store-ack response pulses oDATA_VALID.
- iDRAIN with 2 reads outstanding → no new grants, oIDLE=0 until the second response, then oIDLE=1 the following cycle.
- Read response with empty FIFO → no valid output, oPROTOCOL_ERR=1 sticky; iRESET clears it to 0.
